as_macc_pipe: RTL
=================

AS_MACC_PIPE -- requirements
Module: as_macc_pipe

Interface
REQ-001 Parameter N, 8, data and accumulator width in bits (N >= 4).
REQ-002 Parameter FRAC, N-1, fractional bits of the coefficient operand (0 <= FRAC < N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  command present on op/a_data/b_data.
REQ-006 in_ready  output  1  block accepts the command this cycle.
REQ-007 op  input  2  command code (as_macc_pkg::macc_op_t).
REQ-008 a_data  input  N  unsigned integer operand (pixel/register value).
REQ-009 b_data  input  N  unsigned coefficient (UQ(N-FRAC).FRAC) or immediate.
REQ-010 out_valid  output  1  acc_out holds a new result not yet consumed.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 acc_out  output  N  accumulator value.
REQ-013 z  output  1  acc_out == 0, combinational from the accumulator.
REQ-014 ovf  output  1  sticky saturation flag.

Function
REQ-015 Command accepted on a rising edge where in_valid && in_ready.
REQ-016 Ops: OP_CLR acc<=0 and ovf<=0; OP_LOAD acc<=b_data; OP_ADD acc<=sat(acc+b_data); OP_MACC acc<=sat(acc+((a_data*b_data)>>FRAC)).
REQ-017 Product is computed at full 2N-bit width, then shifted right by FRAC with truncation (no rounding).
REQ-018 The sum is computed at N+1 bits; if bit N is set, acc<=2^N-1 and ovf<=1.
REQ-019 Two-stage pipeline: S1 registers op, b_data and the shifted product; S2 updates the accumulator and sets out_valid.
REQ-020 Latency: a command accepted at edge k updates acc_out and raises out_valid at edge k+2.
REQ-021 Back-to-back commands are accepted every cycle; each S2 update uses the accumulator value written by the previous command (no hazard bubble).
REQ-022 Global stall: in_ready = !(out_valid && !out_ready); while stalled, S1 and S2 hold all state.
REQ-023 out_valid clears on the edge where out_valid && out_ready, unless S2 completes a new result on that same edge, in which case it stays 1.
REQ-024 acc_out, z and ovf remain stable while out_valid=1 and out_ready=0.
REQ-025 An OP_CLR that saturates nothing clears ovf; no other op clears ovf.
REQ-026 Commands presented while in_ready=0 are ignored; the source holds them until accepted.

Reset
REQ-027 On n_reset=0, immediately: acc_out=0, z=1, ovf=0, out_valid=0, S1 valid=0, in_ready=1.
REQ-028 Reset mid-pipeline discards in-flight commands; no out_valid is produced for them after reset release.
REQ-029 Normal operation resumes on the first rising edge after n_reset deasserts.

Structure
REQ-030 Package as_macc_pkg SHALL hold macc_op_t (OP_CLR=0, OP_LOAD=1, OP_ADD=2, OP_MACC=3) and the saturation helper function.
REQ-031 Sub-module as_fxp_mult (parameters N, FRAC) SHALL implement the combinational multiply-and-shift feeding S1.
REQ-032 The N=8, FRAC=7 instance SHALL reproduce existing as_alu ACC/MACC results for non-saturating inputs.

Verification (N=8, FRAC=7)
REQ-033 LOAD b=6, then MACC a=20, b=8'b01100000 -> acc_out=6, then 21 (6+15); out_valid pulses, z=0.
REQ-034 LOAD 250, then ADD 10 -> acc_out=255, ovf=1; then LOAD 3 -> acc_out=3, ovf stays 1; then CLR -> acc_out=0, z=1, ovf=0.
REQ-035 Four back-to-back MACC commands with a=16, b=128 (1.0) after CLR -> acc_out = 16, 32, 48, 64 on consecutive cycles starting 2 cycles after the first accept.
REQ-036 out_ready=0 for 5 cycles with 3 commands offered -> in_ready drops, acc_out stays stable, and no command is lost; all results appear in order after out_ready=1.
REQ-037 Assert n_reset=0 with 2 commands in flight -> acc_out=0, out_valid=0, z=1 asynchronously; no stale result appears after release.
REQ-038 Bench SHALL count tests and errors and print a pass/fail summary at the end.

Source files
------------

// File: rtl/as_macc_pkg.sv
// Shared command codes and the saturation helper for the MAC pipeline.
package as_macc_pkg;

   typedef enum logic [1:0] {
      OP_CLR  = 2'd0,
      OP_LOAD = 2'd1,
      OP_ADD  = 2'd2,
      OP_MACC = 2'd3
   } macc_op_t;

   localparam int unsigned SAT_MAX_W = 64;

   // Clamp an unsigned value to the largest w-bit number.
   function automatic logic [SAT_MAX_W-1:0] sat_u(input logic [SAT_MAX_W-1:0] val,
                                                  input int unsigned          w);
      logic [SAT_MAX_W-1:0] lim;
      lim = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
      return (val > lim) ? lim : val;
   endfunction

endpackage

// File: rtl/as_fxp_mult.sv
// Unsigned integer x UQ fixed-point multiply, truncated back to integer scale.
module as_fxp_mult #(
   parameter int unsigned N    = 8,
   parameter int unsigned FRAC = N - 1
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] prod_c,
   output logic         big_c
);

   localparam int unsigned PW = 2 * N;

   logic [PW-1:0] prod_full;
   logic [PW-1:0] prod_shr;

   assign prod_full = PW'(a_i) * PW'(b_i);
   assign prod_shr  = prod_full >> FRAC;
   assign prod_c    = prod_shr[N-1:0];
   // Any bit above N means the scaled product alone already exceeds the range.
   assign big_c     = |prod_shr[PW-1:N];

endmodule

// File: rtl/as_macc_pipe.sv
// Saturating multiply-accumulate pipeline: operand capture, product register, accumulate.
module as_macc_pipe
   import as_macc_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned FRAC = N - 1
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  macc_op_t     op,
   input  logic [N-1:0] a_data,
   input  logic [N-1:0] b_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] acc_out,
   output logic         z,
   output logic         ovf
);

   localparam int unsigned SW = N + 1;

   logic         stall;

   logic         cap_valid_q, cap_valid_d;
   macc_op_t     cap_op_q,    cap_op_d;
   logic [N-1:0] cap_a_q,     cap_a_d;
   logic [N-1:0] cap_b_q,     cap_b_d;

   logic         s1_valid_q,  s1_valid_d;
   macc_op_t     s1_op_q,     s1_op_d;
   logic [N-1:0] s1_b_q,      s1_b_d;
   logic [N-1:0] s1_prod_q,   s1_prod_d;
   logic         s1_big_q,    s1_big_d;

   logic [N-1:0] acc_q,       acc_d;
   logic         ovf_q,       ovf_d;
   logic         out_valid_q, out_valid_d;

   logic [N-1:0] mult_prod;
   logic         mult_big;
   logic [N-1:0] add_sel;
   logic         big_sel;
   logic [SW-1:0] sum;
   logic         ovf_now;
   logic [N-1:0] acc_sat;

   // One global stall: the whole pipe freezes while a result waits for downstream.
   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;

   as_fxp_mult #(
      .N    (N),
      .FRAC (FRAC)
   ) u_mult (
      .a_i    (cap_a_q),
      .b_i    (cap_b_q),
      .prod_c (mult_prod),
      .big_c  (mult_big)
   );

   // Accumulate datapath reads acc_q directly, so back-to-back commands chain with no bubble.
   assign add_sel = (s1_op_q == OP_MACC) ? s1_prod_q : s1_b_q;
   assign big_sel = (s1_op_q == OP_MACC) & s1_big_q;
   assign sum     = SW'(acc_q) + SW'(add_sel);
   assign ovf_now = big_sel | sum[N];
   assign acc_sat = big_sel ? '1 : N'(sat_u(SAT_MAX_W'(sum), N));

   always_comb begin
      cap_valid_d = cap_valid_q;
      cap_op_d    = cap_op_q;
      cap_a_d     = cap_a_q;
      cap_b_d     = cap_b_q;
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_b_d      = s1_b_q;
      s1_prod_d   = s1_prod_q;
      s1_big_d    = s1_big_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      if (!stall) begin
         cap_valid_d = in_valid;
         cap_op_d    = op;
         cap_a_d     = a_data;
         cap_b_d     = b_data;

         s1_valid_d  = cap_valid_q;
         s1_op_d     = cap_op_q;
         s1_b_d      = cap_b_q;
         s1_prod_d   = mult_prod;
         s1_big_d    = mult_big;

         // Not stalled means any held result is consumed on this edge.
         out_valid_d = 1'b0;
         if (s1_valid_q) begin
            out_valid_d = 1'b1;
            case (s1_op_q)
               OP_CLR: begin
                  acc_d = '0;
                  ovf_d = 1'b0;
               end
               OP_LOAD: acc_d = s1_b_q;
               OP_ADD, OP_MACC: begin
                  acc_d = acc_sat;
                  ovf_d = ovf_q | ovf_now;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cap_valid_q <= 1'b0;
         cap_op_q    <= OP_CLR;
         cap_a_q     <= '0;
         cap_b_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_CLR;
         s1_b_q      <= '0;
         s1_prod_q   <= '0;
         s1_big_q    <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_op_q    <= cap_op_d;
         cap_a_q     <= cap_a_d;
         cap_b_q     <= cap_b_d;
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_b_q      <= s1_b_d;
         s1_prod_q   <= s1_prod_d;
         s1_big_q    <= s1_big_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;
   assign z         = (acc_q == '0);

endmodule
